serial_adder_seq: RTL and testbench

SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/fa_cell.sv | 15 +
 rtl/serial_adder_seq.sv | 95 +++++++++
 tb/tb_serial_adder_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

   // Default operand/result width in bits (legal range 1..32)
   localparam int DEF_WIDTH = 8;

   // Controller states: waiting for operands, shifting bits, presenting result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as the single arithmetic slice of the serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial unsigned adder: {cout,sum} = a + b + cin, one bit per clock through a single full-adder cell.
// Latency: operands accepted in IDLE, WIDTH RUN cycles, result presented in the following cycle.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no accept on the release edge.
module serial_adder_seq
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter holds 0..WIDTH, so it never wraps inside one operation
   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_r;
   logic             carry;
   logic             cout_r;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;

   // The only arithmetic: LSBs of the operand shifters plus the running carry
   fa_cell u_fa (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .c  (carry),
      .s  (fa_s),
      .co (fa_c)
   );

   // Handshake flags are pure state decodes, so no input reaches them combinationally
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;

   // Controller, operand shifters and result registers; reset wins over any handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               // New bit enters at the MSB end; after WIDTH shifts bit 0 sits at the LSB
               sum_r <= (sum_r >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= fa_c;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  // Separate carry-out register so cout survives the next capture of cin
                  cout_r <= fa_c;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed and randomized checks of serial_adder_seq at WIDTH=8 and WIDTH=1.
// Latency: n/a (testbench).
// Backpressure: exercised through out_ready stalls and random consumer readiness.
module tb_serial_adder_seq;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       iv8, ir8, ci8, ov8, or8, co8;
   logic [7:0] a8, b8, s8;

   logic       iv1, ir1, ci1, ov1, or1, co1;
   logic [0:0] a1, b1, s1;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   serial_adder_seq #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .b         (b8),
      .cin       (ci8),
      .out_valid (ov8),
      .out_ready (or8),
      .sum       (s8),
      .cout      (co8)
   );

   serial_adder_seq #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv1),
      .in_ready  (ir1),
      .a         (a1),
      .b         (b1),
      .cin       (ci1),
      .out_valid (ov1),
      .out_ready (or1),
      .sum       (s1),
      .cout      (co1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one operand set to the W=8 instance; inputs are scrambled right after acceptance
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int n = 0;
      while (!ir8 && n < 100) begin
         tick();
         n++;
      end
      iv8 = 1'b1; a8 = a; b8 = b; ci8 = c;
      tick();
      iv8 = 1'b0; a8 = ~a; b8 = ~b; ci8 = ~c;
   endtask

   // lat counts cycles from the accepting cycle to the first cycle with out_valid=1
   task automatic wait_done8(input int start, output int lat);
      lat = start;
      while (!ov8 && lat < 64) begin
         tick();
         lat++;
      end
   endtask

   task automatic pop8();
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] es, input logic ec);
      int lat;
      start8(a, b, c);
      wait_done8(1, lat);
      chk({tag, "_lat"}, lat, 9);
      chk({tag, "_sum"}, s8, es);
      chk({tag, "_cout"}, co8, ec);
      pop8();
      chk({tag, "_idle"}, {ir8, ov8}, 2'b10);
   endtask

   task automatic run1(input string tag, input logic a, input logic b, input logic c,
                       input logic es, input logic ec);
      int lat;
      int n = 0;
      while (!ir1 && n < 100) begin
         tick();
         n++;
      end
      iv1 = 1'b1; a1 = a; b1 = b; ci1 = c;
      tick();
      iv1 = 1'b0; a1 = ~a; b1 = ~b; ci1 = ~c;
      lat = 1;
      while (!ov1 && lat < 64) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_res"}, {co1, s1}, {ec, es});
      or1 = 1'b1;
      tick();
      or1 = 1'b0;
      chk({tag, "_idle"}, {ir1, ov1}, 2'b10);
   endtask

   // Back-to-back operations with a random consumer; queue holds expected {cout,sum}
   task automatic rand_run(input bit w8, input int n, input int budget,
                           output int errs, output int got, output int left);
      logic [32:0] q[$];
      logic [32:0] exp_v;
      logic [32:0] obs_v;
      logic [7:0]  ra, rb;
      logic        rc;
      logic        acc, dlv;
      int          issued = 0;
      int          cyc = 0;
      errs = 0;
      got  = 0;
      while (got < n && cyc < budget) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         if (w8) begin
            iv8 = (issued < n); a8 = ra; b8 = rb; ci8 = rc; or8 = 1'($urandom);
            acc   = iv8 && ir8;
            dlv   = ov8 && or8;
            exp_v = 33'(ra) + 33'(rb) + 33'(rc);
            obs_v = 33'({co8, s8});
         end else begin
            iv1 = (issued < n); a1 = ra[0]; b1 = rb[0]; ci1 = rc; or1 = 1'($urandom);
            acc   = iv1 && ir1;
            dlv   = ov1 && or1;
            exp_v = 33'(ra[0]) + 33'(rb[0]) + 33'(rc);
            obs_v = 33'({co1, s1});
         end
         if (acc) begin
            q.push_back(exp_v);
            issued++;
         end
         if (dlv) begin
            got++;
            if (q.size() == 0) errs++;
            else if (q.pop_front() !== obs_v) errs++;
         end
         tick();
         cyc++;
      end
      iv8 = 1'b0; or8 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
      left = q.size();
   endtask

   initial begin
      int lat;
      int hi;
      int errs, got, left;

      rst_n = 1'b0;
      iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; or8 = 1'b0;
      iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; or1 = 1'b0;
      tick(); tick(); tick();

      // Reset values
      chk("rst_in_ready", ir8, 1'b1);
      chk("rst_out_valid", ov8, 1'b0);
      chk("rst_sum", s8, 8'h00);
      chk("rst_cout", co8, 1'b0);
      chk("rst1_status", {ir1, ov1, co1, s1}, 4'b1000);
      rst_n = 1'b1;
      tick();

      // Directed arithmetic at W=8
      run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
      run8("zero",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      run8("max",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

      // Result stays on the outputs while idle
      tick(); tick(); tick();
      chk("idle_retain", {co8, s8}, 9'h1FF);

      // Backpressure: six stalled DONE cycles, then release with operands offered (no bypass)
      start8(8'h12, 8'h34, 1'b0);
      wait_done8(1, lat);
      chk("bp_lat", lat, 9);
      for (int i = 0; i < 6; i++) begin
         chk("bp_hold", {ov8, ir8, co8, s8}, {1'b1, 1'b0, 1'b0, 8'h46});
         tick();
      end
      iv8 = 1'b1; a8 = 8'h77; b8 = 8'h11; ci8 = 1'b0;
      or8 = 1'b1;
      tick();
      iv8 = 1'b0; or8 = 1'b0;
      chk("bp_release", {ir8, ov8}, 2'b10);
      tick();
      chk("bp_no_bypass", {ir8, ov8}, 2'b10);

      // Inputs during RUN are ignored
      start8(8'h03, 8'h04, 1'b0);
      iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
      tick(); tick(); tick();
      chk("run_busy", ir8, 1'b0);
      iv8 = 1'b0;
      wait_done8(4, lat);
      chk("ign_lat", lat, 9);
      chk("ign_res", {co8, s8}, 9'h007);
      pop8();

      // Reset at RUN bit 4 aborts the operation
      start8(8'h55, 8'h22, 1'b0);
      tick(); tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_status", {ir8, ov8, co8, s8}, {1'b1, 1'b0, 1'b0, 8'h00});
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ov8) hi++;
      end
      chk("abort_no_result", hi, 0);
      chk("abort_idle", ir8, 1'b1);
      run8("post_abort", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

      // Directed arithmetic at W=1
      run1("w1_111", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      run1("w1_100", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run1("w1_001", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      run1("w1_000", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Random back-to-back traffic
      rand_run(1'b1, 1000, 30000, errs, got, left);
      chk("rand8_mismatch", errs, 0);
      chk("rand8_results", got, 1000);
      chk("rand8_leftover", left, 0);
      tick(); tick();
      rand_run(1'b0, 1000, 15000, errs, got, left);
      chk("rand1_mismatch", errs, 0);
      chk("rand1_results", got, 1000);
      chk("rand1_leftover", left, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
